bpu_btb: RTL and testbench
==========================

Name: bpu_btb

Overview:
- Branch prediction unit sitting directly upstream of the PC register. Produces its prdt_taken/prdt_addr inputs.
- Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Lookup is combinational on the current PC, so the PC register can select the predicted target as its next value in the same cycle.
- Execute trains the table with resolved branch/jump outcomes. Training is a registered write.

Parameters:
ADDR_W, 32, instruction address width
ENTRIES, 16, BTB entries (power of 2, >=4)
IDX_W, 4, log2(ENTRIES)
TAG_W, 10, stored tag bits, TAG_W+IDX_W+2 <= ADDR_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  invalidate all entries (jtag reset / fence.i)
pc_i  in  ADDR_W  current fetch PC (PC register output)
prdt_taken_o  out  1  predicted taken for pc_i
prdt_addr_o  out  ADDR_W  predicted target for pc_i
prdt_hit_o  out  1  pc_i hit a valid entry (forwarded down pipe for training)
upd_valid_i  in  1  execute resolved a control-transfer instruction this cycle
upd_pc_i  in  ADDR_W  PC of resolved instruction
upd_uncond_i  in  1  resolved instruction is jal/jalr
upd_taken_i  in  1  actual direction
upd_target_i  in  ADDR_W  actual target
upd_mispredict_i  in  1  execute flagged a mispredict (redirect issued)
mispredict_cnt_o  out  32  count of cycles with upd_valid_i & upd_mispredict_i

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] ignored.
- Entry fields: valid, tag, target[ADDR_W-1:0], ctr[1:0].
- Lookup (0 latency, combinational from registered state):
  - hit = valid & tag match.
  - prdt_hit_o = hit.
  - prdt_taken_o = hit & ctr[1].
  - prdt_addr_o = target when prdt_taken_o, else 0.
- Update on upd_valid_i, written at the clock edge, visible to lookups from the next cycle:
  - Hit, taken: ctr = min(ctr+1, 3); target <= upd_target_i.
  - Hit, not taken: ctr = max(ctr-1, 0). Entry stays valid.
  - Hit or miss with upd_uncond_i: ctr forced to 3, target written, entry allocated if it missed.
  - Miss, taken: allocate (overwrite whatever is at the index): valid=1, tag, target, ctr=2 (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no write-through bypass.
- Flush:
  - flush_i clears every valid bit at the edge. Targets, tags and counters are don't-care.
  - flush_i has priority over a simultaneous update: the update is dropped.
  - mispredict_cnt_o is unaffected by flush_i.
- mispredict_cnt_o increments by 1 when upd_valid_i & upd_mispredict_i. It wraps 0xFFFFFFFF -> 0. upd_mispredict_i without upd_valid_i is ignored.
- Reset (rst=1 at an edge):
  - All valid bits cleared; ctr fields cleared to 0; mispredict_cnt_o = 0.
  - Consequently prdt_taken_o=0, prdt_addr_o=0, prdt_hit_o=0 in the cycle after reset regardless of pc_i.
  - Reset asserted mid-training discards the pending update.
- Stalls: the block has no hold input. The PC register holding pc_i simply repeats the same combinational lookup; updates continue.
- X-safety: tags and targets of invalid entries are never observable on outputs.

Decomposition:
- defines.vh additions: BTB_Entries, BTB_Idx_W, BTB_Tag_W, Ctr_Weak_Taken (2'b10), Ctr_Strong_Taken (2'b11).
- One natural sub-module: bpu_sat_ctr2. Combinational next-state for the 2-bit counter. Inputs: ctr, taken, force. Output: ctr_nxt. Instantiated once on the update path.
- Table storage is flat register arrays (not SRAM), because lookup must be combinational.

Test Plan:
- Reset then pc_i=0x100 -> prdt_hit_o=0, prdt_taken_o=0, prdt_addr_o=0, mispredict_cnt_o=0.
- Allocate on taken miss: upd pc=0x100 taken target=0x200 -> next cycle pc_i=0x100 gives hit=1, taken=1, addr=0x200.
- Training: two not-taken updates on 0x100 (ctr 2->1->0) -> taken=0 after the first, hit stays 1. Four taken updates -> ctr saturates at 3, no wrap to 0.
- Aliasing and simultaneity:
  - pc_i=0x140 (same index, different tag) -> hit=0.
  - Update 0x140 taken target=0x80 while pc_i=0x100 -> same-cycle lookup still returns 0x200; next cycle 0x100 misses, 0x140 hits with target 0x80.
- Flush priority: flush_i and taken update on 0x300 in the same cycle -> next cycle 0x100 and 0x300 both miss.
- Counter: 3 cycles of upd_valid_i & upd_mispredict_i plus 1 cycle of upd_mispredict_i alone -> mispredict_cnt_o=3. Preload-forced 0xFFFFFFFF plus one mispredict -> 0.

Source files
------------

// File: rtl/bpu_btb_pkg.sv
// Shared sizing and counter-state constants for the branch target buffer.
package bpu_btb_pkg;

  localparam int BTB_Entries = 16;
  localparam int BTB_Idx_W   = 4;
  localparam int BTB_Tag_W   = 10;

  localparam logic [1:0] Ctr_Weak_Taken   = 2'b10;
  localparam logic [1:0] Ctr_Strong_Taken = 2'b11;

endpackage

// File: rtl/bpu_sat_ctr2.sv
// Next-state logic for a 2-bit saturating direction counter.
module bpu_sat_ctr2
  import bpu_btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       force_max,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (force_max) begin
      ctr_nxt = Ctr_Strong_Taken;
    end else if (taken) begin
      if (ctr != 2'b11) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with per-entry 2-bit direction counters.
// Lookup is combinational on pc_i; training from execute is a registered write.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = BTB_Entries,
  parameter int IDX_W   = BTB_Idx_W,
  parameter int TAG_W   = BTB_Tag_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              prdt_taken_o,
  output logic [ADDR_W-1:0] prdt_addr_o,
  output logic              prdt_hit_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_uncond_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispredict_i,
  output logic [31:0]       mispredict_cnt_o
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        mis_cnt_q;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic [1:0]       ctr_nxt, ctr_wr;
  logic             unused_pc;

  assign lk_idx  = pc_i[IDX_W+1:2];
  assign lk_tag  = pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{pc_i, upd_pc_i};

  // Invalid entries gate everything, so stale tags/targets never reach the outputs.
  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign prdt_hit_o   = lk_hit;
  assign prdt_taken_o = lk_hit && ctr_q[lk_idx][1];
  assign prdt_addr_o  = prdt_taken_o ? target_q[lk_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  bpu_sat_ctr2 u_sat_ctr (
    .ctr       (ctr_q[upd_idx]),
    .taken     (upd_taken_i),
    .force_max (upd_uncond_i),
    .ctr_nxt   (ctr_nxt)
  );

  // A fresh allocation starts weakly taken; jumps are forced strong by the counter logic.
  assign ctr_wr = (upd_hit || upd_uncond_i) ? ctr_nxt : Ctr_Weak_Taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      if (upd_uncond_i || upd_taken_i) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= ctr_wr;
      end else if (upd_hit) begin
        ctr_q[upd_idx]    <= ctr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt_q <= '0;
    end else if (upd_valid_i && upd_mispredict_i) begin
      mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_bpu_btb.sv
// Scoreboard bench for bpu_btb: directed scenarios then random traffic against an array-based model.
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [31:0] pc_i;
  logic        prdt_taken_o;
  logic [31:0] prdt_addr_o;
  logic        prdt_hit_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_uncond_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispredict_i;
  logic [31:0] mispredict_cnt_o;

  bpu_btb dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .pc_i             (pc_i),
    .prdt_taken_o     (prdt_taken_o),
    .prdt_addr_o      (prdt_addr_o),
    .prdt_hit_o       (prdt_hit_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_uncond_i     (upd_uncond_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_mispredict_i (upd_mispredict_i),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] addr;
    logic [31:0] cnt;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  // Reference model: plain per-index bookkeeping with integer counters.
  bit          m_valid  [16];
  int          m_tag    [16];
  int          m_ctr    [16];
  logic [31:0] m_target [16];
  logic [31:0] m_cnt;

  function automatic int idxOf(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int tagOf(logic [31:0] pc);
    return int'((pc >> 6) % 1024);
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return m_valid[idxOf(pc)] && (m_tag[idxOf(pc)] == tagOf(pc));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_cnt = 0;
  endtask

  task automatic modelUpdate(logic uv, logic [31:0] upc, logic unc, logic tk,
                             logic [31:0] tgt, logic mis, logic fl);
    int i;
    bit h;
    i = idxOf(upc);
    h = modelHit(upc);
    if (uv && mis) m_cnt = m_cnt + 1;
    if (fl) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (uv) begin
      if (unc) begin
        m_valid[i] = 1; m_tag[i] = tagOf(upc); m_target[i] = tgt; m_ctr[i] = 3;
      end else if (h && tk) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = tgt;
      end else if (h) begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = tagOf(upc); m_target[i] = tgt; m_ctr[i] = 2;
      end
    end
  endtask

  // Called at posedge+1: drive one cycle, push the expected lookup, advance the model.
  task automatic applyStimulus(logic [31:0] pc, logic uv, logic [31:0] upc, logic unc,
                               logic tk, logic [31:0] tgt, logic mis, logic fl);
    exp_t e;
    pc_i = pc; upd_valid_i = uv; upd_pc_i = upc; upd_uncond_i = unc;
    upd_taken_i = tk; upd_target_i = tgt; upd_mispredict_i = mis; flush_i = fl;
    e.hit   = modelHit(pc);
    e.taken = e.hit && (m_ctr[idxOf(pc)] >= 2);
    e.addr  = e.taken ? m_target[idxOf(pc)] : 32'h0;
    e.cnt   = m_cnt;
    expq.push_back(e);
    modelUpdate(uv, upc, unc, tk, tgt, mis, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(logic [31:0] pc);
    applyStimulus(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic train(logic [31:0] pc, logic [31:0] upc, logic unc, logic tk, logic [31:0] tgt);
    applyStimulus(pc, 1'b1, upc, unc, tk, tgt, 1'b0, 1'b0);
  endtask

  // Reset with a live update on the inputs, which must be discarded.
  task automatic applyReset();
    rst = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_uncond_i = 1'b1; upd_taken_i = 1'b1;
    upd_target_i = 32'hDEAD_BEE0; upd_mispredict_i = 1'b1; flush_i = 1'b0;
    pc_i = $urandom;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput(exp_t a, exp_t e);
    checks++;
    if (a.hit !== e.hit) begin
      failures++;
      $display("[TB] FAIL hit: got %0b expected %0b at %0t", a.hit, e.hit, $time);
    end
    checks++;
    if (a.taken !== e.taken) begin
      failures++;
      $display("[TB] FAIL taken: got %0b expected %0b at %0t", a.taken, e.taken, $time);
    end
    checks++;
    if (a.addr !== e.addr) begin
      failures++;
      $display("[TB] FAIL addr: got %h expected %h at %0t", a.addr, e.addr, $time);
    end
    checks++;
    if (a.cnt !== e.cnt) begin
      failures++;
      $display("[TB] FAIL mis_cnt: got %0d expected %0d at %0t", a.cnt, e.cnt, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents one response.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.hit = prdt_hit_o; a.taken = prdt_taken_o; a.addr = prdt_addr_o; a.cnt = mispredict_cnt_o;
        checkOutput(a, e);
      end
    end
  end

  initial begin
    logic [31:0] pc, upc;
    int waitCycles;
    rst = 1'b0; flush_i = 1'b0; pc_i = 32'h0; upd_valid_i = 1'b0; upd_pc_i = 32'h0;
    upd_uncond_i = 1'b0; upd_taken_i = 1'b0; upd_target_i = 32'h0; upd_mispredict_i = 1'b0;
    @(posedge clk);
    #1;
    applyReset();

    lookup(32'h100);
    train(32'h100, 32'h100, 1'b0, 1'b1, 32'h200);
    lookup(32'h100);
    train(32'h100, 32'h100, 1'b0, 1'b0, 32'h0);
    train(32'h100, 32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h100);
    repeat (4) train(32'h100, 32'h100, 1'b0, 1'b1, 32'h200);
    lookup(32'h100);
    lookup(32'h140);
    train(32'h100, 32'h140, 1'b0, 1'b1, 32'h80);
    lookup(32'h100);
    lookup(32'h140);
    train(32'h0, 32'h500, 1'b1, 1'b0, 32'h600);
    lookup(32'h500);
    applyStimulus(32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
    lookup(32'h100);
    lookup(32'h300);
    lookup(32'h500);
    repeat (3) applyStimulus(32'h0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    lookup(32'h0);
    applyStimulus(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    lookup(32'h100);

    for (int n = 0; n < 600; n++) begin
      pc  = {$urandom_range(0, 3) << 16, 16'h0} | ($urandom_range(0, 1) << 6)
            | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc = {$urandom_range(0, 3) << 16, 16'h0} | ($urandom_range(0, 1) << 6)
            | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 199) == 0) applyReset();
      applyStimulus(pc, ($urandom_range(0, 1) == 1), upc, ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 63) == 0));
    end

    waitCycles = 0;
    while (expq.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
